// File: rtl/spi_power_pkg.sv
// Shared types for the multi-channel flash-target power sequencer.
// State and event encodings plus counter sizing.
package spi_power_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        ON   = 2'd2,
        DROP = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        EV_NONE   = 2'd0,
        EV_UP     = 2'd1,
        EV_DOWN   = 2'd2,
        EV_GLITCH = 2'd3
    } event_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/spi_power_chan.sv
// One target channel: power-sense synchroniser, power FSM,
// hold/debounce counter and event raise.
module spi_power_chan
    import spi_power_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int POWER_ON_CYCLES  = 65536,
    parameter int POWER_OFF_CYCLES = 16,
    parameter int CNT_W            = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sys_hold,
    input  logic       i_power,
    output logic       o_spi_reset,
    output logic       o_raise,
    output logic [1:0] o_raise_type
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(POWER_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(POWER_OFF_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_p_s;
    chan_state_e            r_state;
    chan_state_e            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_raise;
    logic [1:0]             w_raise_type;
    logic                   r_spi_reset;

    assign w_p_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= '0;
            r_state     <= OFF;
            r_cnt       <= '0;
            r_spi_reset <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_power};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_spi_reset <= (w_state_nxt == OFF) || (w_state_nxt == RAMP);
        end
    end

    // Counter is cleared on every state change so each phase counts from 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_raise      = 1'b0;
        w_raise_type = EV_NONE;
        if (i_sys_hold) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                OFF: begin
                    if (w_p_s) begin
                        w_state_nxt = RAMP;
                        w_cnt_nxt   = '0;
                    end
                end
                RAMP: begin
                    if (!w_p_s) begin
                        w_state_nxt = OFF;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == ON_LAST) begin
                        w_state_nxt  = ON;
                        w_cnt_nxt    = '0;
                        w_raise      = 1'b1;
                        w_raise_type = EV_UP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ON: begin
                    if (!w_p_s) begin
                        w_state_nxt = DROP;
                        w_cnt_nxt   = '0;
                    end
                end
                DROP: begin
                    if (w_p_s) begin
                        w_state_nxt  = ON;
                        w_cnt_nxt    = '0;
                        w_raise      = 1'b1;
                        w_raise_type = EV_GLITCH;
                    end else if (r_cnt == OFF_LAST) begin
                        w_state_nxt  = OFF;
                        w_cnt_nxt    = '0;
                        w_raise      = 1'b1;
                        w_raise_type = EV_DOWN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_spi_reset  = r_spi_reset;
    assign o_raise      = w_raise;
    assign o_raise_type = w_raise_type;

endmodule

// File: rtl/spi_power_sequencer.sv
// Multi-channel power-detect / reset sequencer with a shared,
// fixed-priority event strobe interface.
module spi_power_sequencer
    import spi_power_pkg::*;
#(
    parameter int CHANNELS         = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int POWER_ON_CYCLES  = 65536,
    parameter int POWER_OFF_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sys_hold,
    input  logic [CHANNELS-1:0] power_in,
    output logic [CHANNELS-1:0] spi_reset,
    output logic                event_strobe,
    output logic [2:0]          event_chan,
    output logic [1:0]          event_type,
    output logic                event_overflow
);

    localparam int CNT_W = cnt_width(POWER_ON_CYCLES, POWER_OFF_CYCLES);

    logic [CHANNELS-1:0]       w_raise;
    logic [CHANNELS-1:0][1:0]  w_raise_type;
    logic [CHANNELS-1:0]       r_pend;
    logic [CHANNELS-1:0][1:0]  r_ptype;
    logic [CHANNELS-1:0]       w_gnt;
    logic                      w_gnt_any;
    logic [2:0]                w_gnt_idx;
    logic [1:0]                w_gnt_type;
    logic                      w_ovf;
    logic                      r_strobe;
    logic [2:0]                r_chan;
    logic [1:0]                r_type;
    logic                      r_ovf;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        spi_power_chan #(
            .SYNC_STAGES      (SYNC_STAGES),
            .POWER_ON_CYCLES  (POWER_ON_CYCLES),
            .POWER_OFF_CYCLES (POWER_OFF_CYCLES),
            .CNT_W            (CNT_W)
        ) u_chan (
            .i_clk        (clk),
            .i_rst_n      (reset),
            .i_sys_hold   (sys_hold),
            .i_power      (power_in[c]),
            .o_spi_reset  (spi_reset[c]),
            .o_raise      (w_raise[c]),
            .o_raise_type (w_raise_type[c])
        );
    end

    // Lowest pending index wins; nothing is granted while held off.
    always_comb begin
        w_gnt      = '0;
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_type = EV_NONE;
        if (!sys_hold) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_pend[c] && !w_gnt_any) begin
                    w_gnt[c]   = 1'b1;
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = 3'(c);
                    w_gnt_type = r_ptype[c];
                end
            end
        end
    end

    assign w_ovf = |(w_raise & r_pend & ~w_gnt);

    // A raise wins over a same-cycle grant so the newer event stays queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_ptype <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sys_hold) begin
                    r_pend[c] <= 1'b0;
                end else if (w_raise[c]) begin
                    r_pend[c]  <= 1'b1;
                    r_ptype[c] <= w_raise_type[c];
                end else if (w_gnt[c]) begin
                    r_pend[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_strobe <= 1'b0;
            r_chan   <= '0;
            r_type   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_strobe <= w_gnt_any;
            r_ovf    <= r_ovf | w_ovf;
            if (w_gnt_any) begin
                r_chan <= w_gnt_idx;
                r_type <= w_gnt_type;
            end
        end
    end

    assign event_strobe   = r_strobe;
    assign event_chan     = r_chan;
    assign event_type     = r_type;
    assign event_overflow = r_ovf;

endmodule

// File: tb/tb_spi_power_sequencer.sv
// Directed bench for spi_power_sequencer: 2-channel main instance plus
// a 3-channel instance used to starve a channel into overflow.
module tb_spi_power_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sys_hold = 1'b0;
    logic [1:0] power_in = '0;
    logic [2:0] power_in3 = '0;

    logic [1:0] spi_reset;
    logic       event_strobe;
    logic [2:0] event_chan;
    logic [1:0] event_type;
    logic       event_overflow;

    logic [2:0] spi_reset3;
    logic       event_strobe3;
    logic [2:0] event_chan3;
    logic [1:0] event_type3;
    logic       event_overflow3;

    int checks = 0;
    int failures = 0;
    int ev_n = 0;
    int base;
    logic [2:0] ev_chan = '0;
    logic [1:0] ev_type = '0;
    logic flag;

    spi_power_sequencer #(
        .CHANNELS(2), .SYNC_STAGES(2),
        .POWER_ON_CYCLES(8), .POWER_OFF_CYCLES(4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .sys_hold       (sys_hold),
        .power_in       (power_in),
        .spi_reset      (spi_reset),
        .event_strobe   (event_strobe),
        .event_chan     (event_chan),
        .event_type     (event_type),
        .event_overflow (event_overflow)
    );

    spi_power_sequencer #(
        .CHANNELS(3), .SYNC_STAGES(2),
        .POWER_ON_CYCLES(8), .POWER_OFF_CYCLES(4)
    ) u_dut3 (
        .clk            (clk),
        .reset          (reset),
        .sys_hold       (sys_hold),
        .power_in       (power_in3),
        .spi_reset      (spi_reset3),
        .event_strobe   (event_strobe3),
        .event_chan     (event_chan3),
        .event_type     (event_type3),
        .event_overflow (event_overflow3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (event_strobe) begin
            ev_n++;
            ev_chan = event_chan;
            ev_type = event_type;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset held for 3 cycles
        ticks(3);
        chk("rst_spi_reset", 32'(spi_reset), 32'h3);
        chk("rst_strobe", 32'(event_strobe), 0);
        chk("rst_chan", 32'(event_chan), 0);
        chk("rst_type", 32'(event_type), 0);
        chk("rst_ovf", 32'(event_overflow), 0);
        chk("rst_spi_reset3", 32'(spi_reset3), 32'h7);
        reset = 1'b1;
        ticks(2);
        chk("idle_spi_reset", 32'(spi_reset), 32'h3);

        // 1: power up channel 0
        base = ev_n;
        power_in = 2'b01;
        ticks(10);
        chk("s1_hold", 32'(spi_reset), 32'h3);
        tick();
        chk("s1_fall", 32'(spi_reset), 32'h2);
        tick();
        chk("s1_strobe", 32'(event_strobe), 1);
        chk("s1_chan", 32'(event_chan), 0);
        chk("s1_type", 32'(event_type), 1);
        tick();
        chk("s1_strobe_end", 32'(event_strobe), 0);
        chk("s1_chan_hold", 32'(event_chan), 0);
        chk("s1_type_hold", 32'(event_type), 1);
        chk("s1_count", 32'(ev_n - base), 1);

        // 2: glitch on channel 0
        base = ev_n;
        flag = 1'b0;
        power_in = 2'b00;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) power_in = 2'b01;
            tick();
            if (spi_reset[0]) flag = 1'b1;
        end
        chk("s2_no_reset", 32'(flag), 0);
        chk("s2_count", 32'(ev_n - base), 1);
        chk("s2_type", 32'(ev_type), 3);
        chk("s2_chan", 32'(ev_chan), 0);

        // 3: power loss on channel 0
        base = ev_n;
        power_in = 2'b00;
        ticks(6);
        chk("s3_still_on", 32'(spi_reset), 32'h2);
        tick();
        chk("s3_rise", 32'(spi_reset), 32'h3);
        ticks(5);
        chk("s3_count", 32'(ev_n - base), 1);
        chk("s3_type", 32'(ev_type), 2);
        chk("s3_chan", 32'(ev_chan), 0);

        // 4: both channels ramp in lockstep
        base = ev_n;
        power_in = 2'b11;
        ticks(10);
        chk("s4_hold", 32'(spi_reset), 32'h3);
        tick();
        chk("s4_fall", 32'(spi_reset), 32'h0);
        tick();
        chk("s4_strobe0", 32'(event_strobe), 1);
        chk("s4_chan0", 32'(event_chan), 0);
        chk("s4_type0", 32'(event_type), 1);
        tick();
        chk("s4_strobe1", 32'(event_strobe), 1);
        chk("s4_chan1", 32'(event_chan), 1);
        chk("s4_type1", 32'(event_type), 1);
        tick();
        chk("s4_strobe_end", 32'(event_strobe), 0);
        chk("s4_ovf", 32'(event_overflow), 0);
        chk("s4_count", 32'(ev_n - base), 2);

        // 5a: abort during ramp at cnt=5
        power_in = 2'b00;
        ticks(12);
        base = ev_n;
        power_in = 2'b01;
        ticks(6);
        power_in = 2'b00;
        ticks(6);
        chk("s5_abort_events", 32'(ev_n - base), 0);
        chk("s5_abort_reset", 32'(spi_reset), 32'h3);
        power_in = 2'b11;
        ticks(10);
        chk("s5_restart_hold", 32'(spi_reset), 32'h3);
        tick();
        chk("s5_restart_fall", 32'(spi_reset), 32'h0);

        // 5b: sys_hold with both ON and both up events pending
        base = ev_n;
        sys_hold = 1'b1;
        tick();
        chk("s5_hold_reset", 32'(spi_reset), 32'h3);
        chk("s5_hold_strobe", 32'(event_strobe), 0);
        ticks(2);
        sys_hold = 1'b0;
        ticks(5);
        chk("s5_hold_events", 32'(ev_n - base), 0);
        chk("s5_hold_ovf", 32'(event_overflow), 0);

        // 6: starve channel 2 of the 3-channel instance into overflow
        power_in3 = 3'b111;
        ticks(16);
        chk("s6_up3", 32'(spi_reset3), 32'h0);
        chk("s6_ovf3_clear", 32'(event_overflow3), 0);
        for (int i = 0; i < 8; i++) begin
            power_in3 = (i % 2 == 0) ? 3'b010 : 3'b101;
            tick();
        end
        chk("s6_ovf3_set", 32'(event_overflow3), 1);
        chk("s6_strobe3", 32'(event_strobe3), 1);
        chk("s6_chan3", 32'(event_chan3), 1);
        chk("s6_type3", 32'(event_type3), 3);

        // async reset between clock edges
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_spi_reset3", 32'(spi_reset3), 32'h7);
        chk("s6_rst_strobe3", 32'(event_strobe3), 0);
        chk("s6_rst_chan3", 32'(event_chan3), 0);
        chk("s6_rst_type3", 32'(event_type3), 0);
        chk("s6_rst_ovf3", 32'(event_overflow3), 0);
        chk("s6_rst_spi_reset", 32'(spi_reset), 32'h3);
        chk("s6_rst_strobe", 32'(event_strobe), 0);
        chk("s6_rst_ovf", 32'(event_overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_power_sequencer.md
Name: spi_power_sequencer

Overview:
Multi-channel power-detect and reset sequencer for the flash emulator front end. It replaces the single hard-wired power synchroniser and reset counter with CHANNELS independent targets. Each channel has its own debounced power-loss filter, and a power-on hold time that is set by parameter. Power up, power down and glitch events are reported on one strobe interface that feeds the glue/log path.

Parameters:
CHANNELS, 2, number of emulated flash targets (1..8)
SYNC_STAGES, 2, synchroniser flops on each power_in bit (>=2)
POWER_ON_CYCLES, 65536, clk cycles power must stay high before spi_reset releases (>=2)
POWER_OFF_CYCLES, 16, consecutive low cycles before a power loss is accepted (>=2)
CNT_W, $clog2(max(POWER_ON_CYCLES,POWER_OFF_CYCLES)), derived counter width, not overridden

Ports:
clk  input  1  system clock (133 MHz domain)
reset  input  1  asynchronous, active-low (0 = in reset)
sys_hold  input  1  synchronous force-off (PLL unlocked / user button); all channels to OFF, events suppressed
power_in  input  CHANNELS  raw target power-sense pins, asynchronous
spi_reset  output  CHANNELS  per-channel reset to spi_trx, 1 = held in reset
event_strobe  output  1  one-cycle pulse, event valid
event_chan  output  3  channel index of the event
event_type  output  2  1 = up, 2 = down, 3 = glitch
event_overflow  output  1  sticky; an event was overwritten before it was reported

Behaviour:
- Reset (reset=0):
  - all channel states go to OFF and all counters go to 0.
  - spi_reset is all ones; event_strobe, event_chan, event_type and event_overflow are 0.
  - the synchroniser flops clear to 0.
- Synchroniser: p_s[c] is power_in[c] delayed by SYNC_STAGES flops.
- Per-channel FSM, registered. spi_reset[c] is registered: 1 in OFF/RAMP, 0 in ON/DROP, and it changes on the same edge as the state.
  - OFF: if p_s and !sys_hold, go to RAMP with cnt=0.
  - RAMP:
    - if !p_s, go to OFF (no event).
    - else if cnt==POWER_ON_CYCLES-1, go to ON and raise an up event.
    - else cnt++.
  - ON: if !p_s, go to DROP with cnt=0.
  - DROP:
    - if p_s, go back to ON and raise a glitch event; spi_reset stays 0.
    - else if cnt==POWER_OFF_CYCLES-1, go to OFF and raise a down event.
    - else cnt++.
  - sys_hold=1 overrides every state and transition: the next state is OFF, cnt=0, no event is raised, and any pending events are cleared.
- Latency: a power_in rise held stable makes spi_reset fall exactly SYNC_STAGES+POWER_ON_CYCLES rising edges after the first edge that samples it high. A power loss makes spi_reset rise SYNC_STAGES+POWER_OFF_CYCLES edges after the first low sample.
- Event path:
  - each channel has a pending bit and a 2-bit type register.
  - a newly raised event sets pending and its type. If pending was already set and not granted this cycle, the type is overwritten and event_overflow is set (sticky until reset).
  - arbiter: fixed priority, lowest channel index wins. At most one grant per cycle.
  - a grant drives event_strobe=1 with event_chan and event_type registered on the next cycle, then clears that channel's pending bit.
  - raise and grant on the same channel in the same cycle: the new event stays pending, with no overflow.
  - event_chan and event_type hold their last values while event_strobe=0.
- Counters never wrap; comparison is by equality at the terminal value.
- Bits of event_chan above $clog2(CHANNELS) are 0.

Decomposition:
- Package spi_power_pkg holds:
  - the state encoding: OFF=0, RAMP=1, ON=2, DROP=3.
  - the event codes EV_NONE=0, EV_UP=1, EV_DOWN=2, EV_GLITCH=3.
- Sub-module spi_power_chan contains the synchroniser, FSM, counter and event raise for one channel.
- The top generates CHANNELS instances of spi_power_chan, plus the pending registers, priority arbiter and output registers.

Test Plan:
All scenarios use CHANNELS=2, SYNC_STAGES=2, POWER_ON_CYCLES=8, POWER_OFF_CYCLES=4.
1. Reset and power up: hold reset=0 for 3 cycles, release, then set power_in=2'b01 -> spi_reset[0] falls exactly 10 edges later; one event_strobe follows with chan=0, type=1; spi_reset[1] stays 1.
2. Glitch: channel 0 ON, pulse power_in[0] low for 3 cycles -> spi_reset[0] stays 0; one event with type=3; no down event.
3. Power loss: channel 0 ON, drop power_in[0] for 10 cycles -> spi_reset[0] rises 6 edges after the first low sample; one event with chan=0, type=2.
4. Simultaneous events: both channels ramp in lockstep -> two strobes on consecutive cycles, chan 0 then chan 1, both type=1; event_overflow=0.
5. Abort during ramp and sys_hold:
   - power drops during RAMP at cnt=5 -> no event; the next rise restarts the full 8-cycle count.
   - sys_hold=1 with both channels ON -> spi_reset=2'b11 on the next edge; no events; pending bits cleared.
6. Async reset mid-operation: assert reset=0 in DROP with an event pending -> outputs reach their reset values immediately, without a clock edge; event_overflow cleared.
